// File: rtl/telemetry_pkg.sv
// Shared telemetry SRAM definitions: pointer widths, reader state encoding
// and the default frame sync word.
package telemetry_pkg;

  localparam int SRAM_ADDR_W      = 19;
  localparam int SRAM_CHIP_ADDR_W = 18;
  localparam int RD_WAIT_W        = 4;

  localparam logic [15:0] DEF_SYNC_WORD = 16'hEB90;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SEND   = 3'd3,
    ST_HDR_HI = 3'd4,
    ST_HDR_LO = 3'd5
  } rd_state_e;

  // Read pointer spans both chips and wraps naturally at 2^19.
  function automatic logic [SRAM_ADDR_W-1:0] ptr_next(input logic [SRAM_ADDR_W-1:0] p);
    return p + SRAM_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/sram_tx_reader.sv
// Streams stored telemetry bytes from the 512K x 8 SRAM to the serializer
// while the transmit window is open. TX_SYNC_HDR_EN adds a per-frame sync header.
module sram_tx_reader
  import telemetry_pkg::*;
#(
  parameter int          RD_WAIT   = 3,
  parameter int          FRAME_LEN = 64,
  parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD
) (
  input  logic                        CLK_48MHZ,
  input  logic                        reset,
  input  logic                        tx_enable,
  input  logic [SRAM_CHIP_ADDR_W-1:0] write_address,
  input  logic                        w_chip_select,
  input  logic                        mem_busy,
  input  logic [7:0]                  mem_data,
  output logic [SRAM_CHIP_ADDR_W-1:0] read_address,
  output logic                        r_chip_select,
  output logic                        mem_oe_n,
  output logic                        mem_rd_active,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready
);

  rd_state_e                state_q, state_d;
  logic [RD_WAIT_W-1:0]     wait_q, wait_d;
  logic [SRAM_ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic                     tx_valid_q, tx_valid_d;

  logic empty, start, abort, hs;

`ifdef TX_SYNC_HDR_EN
  localparam int FC_W = ($clog2(FRAME_LEN) > 0) ? $clog2(FRAME_LEN) : 1;

  logic [FC_W-1:0] frame_q, frame_d;
  logic            hdr_done_q, hdr_done_d;
  logic            en_q;
`endif

  assign empty = (rd_ptr_q == {w_chip_select, write_address});
  assign start = tx_enable && !empty && !mem_busy;
  assign abort = mem_busy || !tx_enable;
  assign hs    = tx_valid_q && tx_ready;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    rd_ptr_d   = rd_ptr_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
`ifdef TX_SYNC_HDR_EN
    frame_d    = frame_q;
    hdr_done_d = hdr_done_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef TX_SYNC_HDR_EN
          if (frame_q == '0 && !hdr_done_q) begin
            state_d    = ST_HDR_HI;
            tx_data_d  = SYNC_WORD[15:8];
            tx_valid_d = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
`else
          state_d = ST_ADDR;
`endif
        end
      end

      ST_ADDR: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          wait_d  = RD_WAIT_W'(RD_WAIT - 1);
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Abort wins over capture so a byte read under a writer collision is never sent.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (wait_q == '0) begin
          tx_data_d  = mem_data;
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end else begin
          wait_d = wait_q - RD_WAIT_W'(1);
        end
      end

      ST_SEND: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          rd_ptr_d   = ptr_next(rd_ptr_q);
          state_d    = ST_IDLE;
`ifdef TX_SYNC_HDR_EN
          if (frame_q == FC_W'(FRAME_LEN - 1)) begin
            frame_d    = '0;
            hdr_done_d = 1'b0;
          end else begin
            frame_d = frame_q + FC_W'(1);
          end
`endif
        end
      end

`ifdef TX_SYNC_HDR_EN
      ST_HDR_HI: begin
        if (hs) begin
          if (tx_enable) begin
            tx_data_d = SYNC_WORD[7:0];
            state_d   = ST_HDR_LO;
          end else begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end

      ST_HDR_LO: begin
        if (hs) begin
          tx_valid_d = 1'b0;
          hdr_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

`ifdef TX_SYNC_HDR_EN
    // Each new window restarts framing so it always opens with a header.
    if (tx_enable && !en_q) begin
      frame_d    = '0;
      hdr_done_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge CLK_48MHZ or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      rd_ptr_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      rd_ptr_q   <= rd_ptr_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

`ifdef TX_SYNC_HDR_EN
  always_ff @(posedge CLK_48MHZ or negedge reset) begin
    if (!reset) begin
      frame_q    <= '0;
      hdr_done_q <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      frame_q    <= frame_d;
      hdr_done_q <= hdr_done_d;
      en_q       <= tx_enable;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{SYNC_WORD, 32'(FRAME_LEN)};
`endif

  assign read_address  = rd_ptr_q[SRAM_CHIP_ADDR_W-1:0];
  assign r_chip_select = rd_ptr_q[SRAM_ADDR_W-1];
  assign mem_rd_active = (state_q == ST_ADDR) || (state_q == ST_WAIT);
  assign mem_oe_n      = !mem_rd_active;
  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;

endmodule

// File: tb/tb_sram_tx_reader.sv
// Scoreboard bench for sram_tx_reader: an SRAM/writer model queues every stored
// byte; a monitor pops and compares on each serializer handshake.
module tb_sram_tx_reader;
  import telemetry_pkg::*;

`ifdef TX_SYNC_HDR_EN
  localparam int FRAME_LEN = 4;
`else
  localparam int FRAME_LEN = 64;
`endif
  localparam int RD_WAIT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_enable = 1'b0;
  logic        mem_busy = 1'b0;
  logic        tx_ready = 1'b0;
  logic [18:0] wr_ptr = '0;
  logic [7:0]  mem_data;
  logic [17:0] read_address;
  logic        r_cs, mem_oe_n, mem_rd_active, tx_valid;
  logic [7:0]  tx_data;

  logic [7:0]  sram [0:524287];
  logic [7:0]  exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  sram_tx_reader #(.RD_WAIT(RD_WAIT), .FRAME_LEN(FRAME_LEN), .SYNC_WORD(DEF_SYNC_WORD)) dut (
    .CLK_48MHZ(clk), .reset(rst_n), .tx_enable(tx_enable),
    .write_address(wr_ptr[17:0]), .w_chip_select(wr_ptr[18]),
    .mem_busy(mem_busy), .mem_data(mem_data),
    .read_address(read_address), .r_chip_select(r_cs),
    .mem_oe_n(mem_oe_n), .mem_rd_active(mem_rd_active),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  // Bus is garbage whenever OE is off or the writer owns it.
  assign mem_data = (!mem_oe_n && !mem_busy) ? sram[{r_cs, read_address}] : 8'hEE;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_byte: got %0h expected none", tx_data);
      end else begin
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd_ptr();
    return {13'd0, r_cs, read_address};
  endfunction

  task automatic store(input logic [7:0] b);
    sram[wr_ptr] = b;
    exp_q.push_back(b);
    wr_ptr = wr_ptr + 19'd1;
  endtask

  task automatic drain(input int bound, input string nm);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick;
    if (exp_q.size() != 0) timeout(nm);
  endtask

  // which: 0 = tx_valid, 1 = mem_rd_active
  task automatic wait_for(input int which, input string nm);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      hit = (which == 0) ? tx_valid : mem_rd_active;
      if (!hit) tick;
    end
    if (!hit) timeout(nm);
  endtask

  task automatic check_reset_vals(input string nm);
    check({nm, "_rd_ptr"},   rd_ptr(), 32'd0);
    check({nm, "_oe_n"},     {31'd0, mem_oe_n}, 32'd1);
    check({nm, "_rd_act"},   {31'd0, mem_rd_active}, 32'd0);
    check({nm, "_tx_data"},  {24'd0, tx_data}, 32'd0);
    check({nm, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
  endtask

  task automatic async_reset_mid_op;
    tx_enable = 1'b0;
    tick;
    store(8'h91);
    store(8'h92);
    tx_ready  = 1'b0;
    tx_enable = 1'b1;
    wait_for(0, "reset_wait_valid");
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    exp_q.delete();
    tx_enable = 1'b0;
    tick;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] k;
    logic        seen;
    logic [7:0]  b;

    tick;
    tick;
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick;

`ifdef TX_SYNC_HDR_EN
    // Model: each FRAME_LEN payload bytes are preceded by the sync word, MSB first.
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      sram[wr_ptr] = b;
      wr_ptr = wr_ptr + 19'd1;
      if (i % FRAME_LEN == 0) begin
        exp_q.push_back(DEF_SYNC_WORD[15:8]);
        exp_q.push_back(DEF_SYNC_WORD[7:0]);
      end
      exp_q.push_back(b);
    end
    tx_ready  = 1'b1;
    tx_enable = 1'b1;
    drain(400, "hdr_drain");
    repeat (8) tick;
    check("hdr_rd_ptr", rd_ptr(), {13'd0, wr_ptr});
    check("hdr_idle_valid", {31'd0, tx_valid}, 32'd0);
    async_reset_mid_op();
`else
    // Basic in-order stream with latency measurement.
    for (int i = 0; i < 5; i++) store(8'h11 + 8'(i));
    tx_ready  = 1'b1;
    tx_enable = 1'b1;
    wait_for(1, "lat_wait_addr");
    k = 0;
    while (!tx_valid && k < 40) begin
      tick;
      k++;
    end
    check("addr_to_valid_latency", k, RD_WAIT + 1);
    drain(200, "basic_drain");
    repeat (10) tick;
    check("basic_rd_ptr", rd_ptr(), 32'h5);
    check("basic_empty_valid", {31'd0, tx_valid}, 32'd0);
    check("basic_empty_rd_act", {31'd0, mem_rd_active}, 32'd0);

    // Serializer stalls: byte and valid must hold.
    tx_enable = 1'b0;
    tick;
    store(8'hA5);
    tx_ready  = 1'b0;
    tx_enable = 1'b1;
    wait_for(0, "stall_wait_valid");
    seen = 1'b1;
    for (int i = 0; i < 20; i++) begin
      seen = seen & tx_valid & (tx_data == 8'hA5);
      tick;
    end
    check("stall_hold", {31'd0, seen}, 32'd1);
    check("stall_ptr_before", rd_ptr(), {13'd0, wr_ptr - 19'd1});
    tx_ready = 1'b1;
    drain(20, "stall_drain");
    tick;
    check("stall_ptr_after", rd_ptr(), {13'd0, wr_ptr});

    // Writer collision during WAIT: abort and re-read the same byte.
    tx_enable = 1'b0;
    tick;
    store(8'h3C);
    tx_enable = 1'b1;
    wait_for(1, "busy_wait_addr");
    tick;
    mem_busy = 1'b1;
    tick;
    mem_busy = 1'b0;
    check("busy_oe_released", {31'd0, mem_oe_n}, 32'd1);
    check("busy_ptr_held", rd_ptr(), {13'd0, wr_ptr - 19'd1});
    drain(40, "busy_drain");
    repeat (6) tick;
    check("busy_ptr_after", rd_ptr(), {13'd0, wr_ptr});

    // Window closes during WAIT: no byte presented.
    tx_enable = 1'b0;
    tick;
    store(8'h5A);
    tx_enable = 1'b1;
    wait_for(1, "endrop_wait_addr");
    tick;
    tx_enable = 1'b0;
    tick;
    check("endrop_wait_idle", {31'd0, mem_rd_active}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen = seen | tx_valid;
      tick;
    end
    check("endrop_wait_no_valid", {31'd0, seen}, 32'd0);
    tx_enable = 1'b1;
    drain(40, "endrop_wait_drain");

    // Window closes during SEND: presented byte still completes.
    tx_enable = 1'b0;
    tick;
    store(8'h77);
    tx_ready  = 1'b0;
    tx_enable = 1'b1;
    wait_for(0, "endrop_send_valid");
    tx_enable = 1'b0;
    repeat (5) tick;
    check("endrop_send_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h77});
    tx_ready = 1'b1;
    drain(20, "endrop_send_drain");
    repeat (3) tick;
    check("endrop_send_idle_valid", {31'd0, tx_valid}, 32'd0);
    check("endrop_send_ptr", rd_ptr(), {13'd0, wr_ptr});

    // Chip boundary: last byte of chip 0, then address 0 of chip 1.
    tick;
    force dut.rd_ptr_q = 19'h3FFFF;
    tick;
    release dut.rd_ptr_q;
    tick;
    check("chip_preset", rd_ptr(), 32'h3FFFF);
    wr_ptr = 19'h3FFFF;
    store(8'hC1);
    store(8'hC2);
    tx_enable = 1'b1;
    drain(40, "chip_drain");
    tick;
    check("chip_ptr", rd_ptr(), 32'h40001);
    check("chip_cs", {31'd0, r_cs}, 32'd1);

    // Top of memory wraps to zero.
    tx_enable = 1'b0;
    tick;
    force dut.rd_ptr_q = 19'h7FFFF;
    tick;
    release dut.rd_ptr_q;
    wr_ptr = 19'h7FFFF;
    store(8'hD1);
    store(8'hD2);
    tx_enable = 1'b1;
    drain(40, "wrap_drain");
    tick;
    check("wrap_ptr", rd_ptr(), 32'h1);
    check("wrap_cs", {31'd0, r_cs}, 32'd0);

    // Randomized traffic: writer collisions, window toggles, serializer stalls.
    for (int i = 0; i < 600; i++) begin
      tx_ready = ($urandom_range(3) != 0);
      if ($urandom_range(15) == 0) tx_enable = ~tx_enable;
      if (exp_q.size() < 12 && $urandom_range(3) == 0) begin
        mem_busy = 1'b1;
        store(8'($urandom));
      end else begin
        mem_busy = ($urandom_range(15) == 0);
      end
      tick;
    end
    mem_busy  = 1'b0;
    tx_ready  = 1'b1;
    tx_enable = 1'b1;
    drain(400, "rand_drain");
    tick;
    check("rand_ptr", rd_ptr(), {13'd0, wr_ptr});

    async_reset_mid_op();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
